// File: rtl/vend_coin_scheduler_if.sv
// Bundle shared between the coin scheduler and its environment.
// Slot side: slot_coin_5/slot_coin_10 in, reject/vend_done/change_done out.
// Core side: coin_5/coin_10 out, dispense/change_5 in.
// Status: owner, owner_valid, err.
// master = scheduler, slave = environment (slots plus vending core).
interface vend_coin_scheduler_if #(
  parameter int unsigned N_SLOTS = 2
);
  localparam int unsigned OW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  logic [N_SLOTS-1:0] slot_coin_5;
  logic [N_SLOTS-1:0] slot_coin_10;
  logic               coin_5;
  logic               coin_10;
  logic               dispense;
  logic               change_5;
  logic [OW-1:0]      owner;
  logic               owner_valid;
  logic [N_SLOTS-1:0] reject;
  logic [N_SLOTS-1:0] vend_done;
  logic [N_SLOTS-1:0] change_done;
  logic               err;

  modport master (
    input  slot_coin_5, slot_coin_10, dispense, change_5,
    output coin_5, coin_10, owner, owner_valid, reject, vend_done,
           change_done, err
  );

  modport slave (
    output slot_coin_5, slot_coin_10, dispense, change_5,
    input  coin_5, coin_10, owner, owner_valid, reject, vend_done,
           change_done, err
  );
endinterface

// File: rtl/vend_coin_scheduler.sv
// Shares one vending core between N_SLOTS coin slots. Each slot buffers coins
// in a small FIFO; sessions are granted round-robin and the owner's coins are
// fed to the core one per cycle until credit reaches 15, then one HOLD cycle
// lines up with the core's dispense cycle while a shadow credit checks it.
// Ports: clk, rst (sync, active-high), bus (vend_coin_scheduler_if.master).
module vend_coin_scheduler #(
  parameter int unsigned N_SLOTS    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  vend_coin_scheduler_if.master bus
);
  localparam int unsigned OW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, SESSION, HOLD} state_t;

  state_t             state, state_nxt;
  logic [OW-1:0]      owner_q, owner_nxt, rr_ptr, rr_nxt, grant;
  logic               grant_found;
  logic [CW-1:0]      credit, credit_nxt;
  logic               err_q, err_set;
  logic [N_SLOTS-1:0] reject_q;
  logic               coin_5_c, coin_10_c;
  logic [N_SLOTS-1:0] vend_done_c, change_done_c;
  int unsigned        idx;

  logic [FIFO_DEPTH-1:0] mem    [N_SLOTS];
  logic [PW-1:0]         wr_ptr [N_SLOTS];
  logic [PW-1:0]         rd_ptr [N_SLOTS];
  logic [N_SLOTS-1:0]    empty, full, head, pop, push, push_bad;

  // FIFO status; the extra pointer bit separates full from empty
  always_comb begin
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      head[i]  = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  // Push acceptance; a full FIFO still takes a coin when it pops that cycle
  always_comb begin
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      push[i]     = (bus.slot_coin_5[i] ^ bus.slot_coin_10[i]) &&
                    (!full[i] || pop[i]);
      push_bad[i] = (bus.slot_coin_5[i] && bus.slot_coin_10[i]) ||
                    ((bus.slot_coin_5[i] ^ bus.slot_coin_10[i]) &&
                     full[i] && !pop[i]);
    end
  end

  // Next state, pops and core-facing outputs
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner_q;
    rr_nxt        = rr_ptr;
    credit_nxt    = credit;
    pop           = '0;
    coin_5_c      = 1'b0;
    coin_10_c     = 1'b0;
    vend_done_c   = '0;
    change_done_c = '0;
    grant         = '0;
    grant_found   = 1'b0;
    idx           = 0;

    // first non-empty slot at or after rr_ptr, wrapping
    for (int unsigned k = 0; k < N_SLOTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_SLOTS) idx = idx - N_SLOTS;
      if (!grant_found && !empty[OW'(idx)]) begin
        grant       = OW'(idx);
        grant_found = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (grant_found) begin
          owner_nxt = grant;
          state_nxt = SESSION;
        end
      end
      SESSION: begin
        if (!empty[owner_q]) begin
          pop[owner_q] = 1'b1;
          coin_10_c    = head[owner_q];
          coin_5_c     = !head[owner_q];
          credit_nxt   = credit + (head[owner_q] ? 3'd2 : 3'd1);
          if (credit_nxt >= 3'd3) state_nxt = HOLD;
        end
      end
      HOLD: begin
        vend_done_c[owner_q]   = 1'b1;
        change_done_c[owner_q] = (credit == 3'd4);
        state_nxt              = IDLE;
        credit_nxt             = '0;
        rr_nxt                 = (owner_q == OW'(N_SLOTS - 1)) ? '0 : owner_q + OW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Core response check against the shadow credit
  always_comb begin
    if (state == HOLD) err_set = !bus.dispense || (bus.change_5 != (credit == 3'd4));
    else               err_set = bus.dispense;
  end

  // Control state, FIFO pointers and registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner_q  <= '0;
      rr_ptr   <= '0;
      credit   <= '0;
      err_q    <= 1'b0;
      reject_q <= '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      owner_q  <= owner_nxt;
      rr_ptr   <= rr_nxt;
      credit   <= credit_nxt;
      err_q    <= err_q | err_set;
      reject_q <= push_bad;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
      end
    end
  end

  // FIFO storage: 0 = 5, 1 = 10
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= bus.slot_coin_10[i];
    end
  end

  assign bus.coin_5      = coin_5_c;
  assign bus.coin_10     = coin_10_c;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = (state != IDLE);
  assign bus.reject      = reject_q;
  assign bus.vend_done   = vend_done_c;
  assign bus.change_done = change_done_c;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_vend_coin_scheduler.sv
// Bench for vend_coin_scheduler: a behavioural vending core answers the
// scheduler, directed stimulus pushes expected core coins, vends and rejects
// into queues, and a negedge monitor pops and compares them.
module tb_vend_coin_scheduler;
  localparam int unsigned N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  logic force_bad = 1'b0;
  int total = 0;
  int bad = 0;

  int exp_coin[$];
  int exp_vend[$];
  int exp_rej[$];

  vend_coin_scheduler_if #(.N_SLOTS(N)) bus ();

  vend_coin_scheduler #(.N_SLOTS(N), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural core: credit in 5 units, dispense cycle after reaching 15
  logic [2:0] cc;
  logic       disp_st;
  always @(posedge clk) begin
    if (rst) begin
      cc      <= 3'd0;
      disp_st <= 1'b0;
    end else if (disp_st) begin
      cc      <= 3'd0;
      disp_st <= 1'b0;
    end else if (bus.coin_5 || bus.coin_10) begin
      cc      <= cc + (bus.coin_10 ? 3'd2 : 3'd1);
      disp_st <= ((cc + (bus.coin_10 ? 3'd2 : 3'd1)) >= 3'd3);
    end
  end
  assign bus.dispense = disp_st & ~force_bad;
  assign bus.change_5 = disp_st & (cc == 3'd4);

  function automatic void chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic int coin_code(input int slot, input int ten);
    return slot * 4 + (ten ? 2 : 1);
  endfunction

  function automatic int vend_code(input int slot, input int chg);
    return (chg << 16) | ((chg << slot) << 8) | (1 << slot);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    int got, exp;
    if (mon_en && !rst) begin
      if (bus.coin_5 || bus.coin_10) begin
        got = int'(bus.owner) * 4 + (bus.coin_10 ? 2 : 0) + (bus.coin_5 ? 1 : 0);
        exp = (exp_coin.size() > 0) ? exp_coin.pop_front() : -1;
        chk("core_coin", got, exp);
      end
      if (bus.vend_done != '0) begin
        got = (int'(bus.change_5) << 16) | (int'(bus.change_done) << 8) | int'(bus.vend_done);
        exp = (exp_vend.size() > 0) ? exp_vend.pop_front() : -1;
        chk("vend", got, exp);
      end
      if (bus.reject != '0) begin
        got = int'(bus.reject);
        exp = (exp_rej.size() > 0) ? exp_rej.pop_front() : -1;
        chk("reject", got, exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [N-1:0] c5, input logic [N-1:0] c10);
    bus.slot_coin_5  = c5;
    bus.slot_coin_10 = c10;
    tick();
    bus.slot_coin_5  = '0;
    bus.slot_coin_10 = '0;
  endtask

  initial begin
    bus.slot_coin_5  = '0;
    bus.slot_coin_10 = '0;
    rst = 1'b1;
    idle(2);

    // reset state
    @(negedge clk);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_owner_valid", int'(bus.owner_valid), 0);
    chk("rst_coins", int'({bus.coin_5, bus.coin_10}), 0);
    chk("rst_flags", int'({bus.reject, bus.vend_done, bus.change_done}), 0);
    chk("rst_err", int'(bus.err), 0);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // single 15 session on slot 0, cycle-exact
    exp_coin.push_back(coin_code(0, 0));
    exp_coin.push_back(coin_code(0, 1));
    exp_vend.push_back(vend_code(0, 0));
    pulse(2'b01, 2'b00);
    pulse(2'b00, 2'b01);
    @(negedge clk);
    chk("t1_first_issue", int'({bus.owner_valid, bus.coin_5, bus.coin_10}), 3'b110);
    tick();
    @(negedge clk);
    chk("t1_second_issue", int'({bus.coin_5, bus.coin_10}), 2'b01);
    tick();
    @(negedge clk);
    chk("t1_hold", int'({bus.owner_valid, bus.vend_done}), 3'b101);
    tick();
    @(negedge clk);
    chk("t1_idle", int'(bus.owner_valid), 0);
    idle(3);
    chk("t1_err", int'(bus.err), 0);

    // change case on slot 1
    exp_coin.push_back(coin_code(1, 1));
    exp_coin.push_back(coin_code(1, 1));
    exp_vend.push_back(vend_code(1, 1));
    pulse(2'b00, 2'b10);
    pulse(2'b00, 2'b10);
    idle(8);
    chk("t2_err", int'(bus.err), 0);

    // round-robin, no preemption
    exp_coin.push_back(coin_code(0, 1));
    exp_coin.push_back(coin_code(0, 0));
    exp_coin.push_back(coin_code(1, 1));
    exp_coin.push_back(coin_code(1, 0));
    exp_vend.push_back(vend_code(0, 0));
    exp_vend.push_back(vend_code(1, 0));
    pulse(2'b00, 2'b11);
    pulse(2'b11, 2'b00);
    idle(14);
    chk("t3_rr_ptr", int'(dut.rr_ptr), 0);
    chk("t3_err", int'(bus.err), 0);

    // overflow while slot 1 owns an idle session, then illegal double pulse
    exp_coin.push_back(coin_code(1, 0));
    exp_coin.push_back(coin_code(1, 1));
    exp_coin.push_back(coin_code(0, 1));
    exp_coin.push_back(coin_code(0, 0));
    exp_coin.push_back(coin_code(0, 0));
    exp_coin.push_back(coin_code(0, 1));
    exp_vend.push_back(vend_code(1, 0));
    exp_vend.push_back(vend_code(0, 0));
    exp_vend.push_back(vend_code(0, 0));
    exp_rej.push_back(1);
    exp_rej.push_back(2);
    pulse(2'b10, 2'b00);
    idle(3);
    chk("t4_owner_slot1", int'({bus.owner_valid, bus.owner}), 2'b11);
    pulse(2'b00, 2'b01);
    pulse(2'b01, 2'b00);
    pulse(2'b01, 2'b00);
    pulse(2'b00, 2'b01);
    pulse(2'b01, 2'b00);
    @(negedge clk);
    chk("t4_reject_timing", int'(bus.reject), 1);
    pulse(2'b10, 2'b10);
    @(negedge clk);
    chk("t4_double_reject", int'(bus.reject), 2);
    idle(2);
    pulse(2'b00, 2'b10);
    idle(20);
    chk("t4_err", int'(bus.err), 0);

    // core mismatch: dispense suppressed in HOLD
    force_bad = 1'b1;
    exp_coin.push_back(coin_code(0, 1));
    exp_coin.push_back(coin_code(0, 0));
    exp_vend.push_back(vend_code(0, 0));
    pulse(2'b00, 2'b01);
    pulse(2'b01, 2'b00);
    idle(8);
    force_bad = 1'b0;
    chk("t5_err_set", int'(bus.err), 1);
    idle(6);
    chk("t5_err_sticky", int'(bus.err), 1);

    // reset mid-session: 10 issued, two 5s buffered
    exp_coin.push_back(coin_code(0, 1));
    pulse(2'b00, 2'b01);
    pulse(2'b01, 2'b00);
    pulse(2'b01, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_outputs", int'({bus.owner, bus.owner_valid, bus.coin_5, bus.coin_10,
                           bus.reject, bus.vend_done, bus.change_done}), 0);
    chk("t6_err_cleared", int'(bus.err), 0);
    chk("t6_state_idle", int'(dut.state), 0);
    chk("t6_fifos_empty", int'(dut.empty), 3);
    idle(10);
    chk("t6_quiet", int'(bus.owner_valid), 0);

    chk("left_coin", exp_coin.size(), 0);
    chk("left_vend", exp_vend.size(), 0);
    chk("left_reject", exp_rej.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vend_coin_scheduler.md
# vend_coin_scheduler

Session-based scheduler that shares one `vending_machine` core between `N_SLOTS` coin slots. It buffers coin pulses per slot and grants the core to one slot at a time, round-robin. It then feeds the owner's coins to the core one per cycle and holds off issue while the core is in its dispense cycle, during which the core drops coins. A shadow credit model checks the core's `dispense`/`change_5` response.

## Interface
Parameters:
- `N_SLOTS`, default 2: number of coin slots (2..8).
- `FIFO_DEPTH`, default 4: pending-coin entries per slot (power of 2).

Ports:
- `clk`, in, 1: the only clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `slot_coin_5`, in, `N_SLOTS`: per-slot single-cycle ₹5 coin pulse.
- `slot_coin_10`, in, `N_SLOTS`: per-slot single-cycle ₹10 coin pulse.
- `coin_5`, out, 1: ₹5 pulse to the core.
- `coin_10`, out, 1: ₹10 pulse to the core.
- `dispense`, in, 1: from the core.
- `change_5`, in, 1: from the core.
- `owner`, out, `$clog2(N_SLOTS)` (min 1): slot currently holding the core.
- `owner_valid`, out, 1: a session is active (SESSION or HOLD).
- `reject`, out, `N_SLOTS`: per-slot pulse; the coin was refused and must be returned.
- `vend_done`, out, `N_SLOTS`: per-slot pulse; product dispensed for that slot.
- `change_done`, out, `N_SLOTS`: per-slot pulse; ₹5 change returned for that slot.
- `err`, out, 1: sticky; core response mismatched the shadow credit.

## Operation
- **Per-slot FIFO**, 1-bit entries (0 = ₹5, 1 = ₹10).
  - A pulse on exactly one of `slot_coin_5[i]`/`slot_coin_10[i]` pushes into FIFO i.
  - Both pulses in the same cycle: no push, `reject[i]`=1 next cycle.
  - Push to a full FIFO: no push, `reject[i]`=1 next cycle, unless FIFO i is popped in the same cycle, in which case the push is accepted.
- **Shadow credit**: 3-bit count in ₹5 units, legal values 0..4.
- **FSM IDLE**
  - If any FIFO is non-empty, grant the first non-empty slot at or after `rr_ptr` (wrapping).
  - Register `owner` and go to SESSION.
  - Otherwise stay in IDLE.
- **FSM SESSION**
  - If the owner's FIFO is non-empty, pop its head and drive `coin_5` or `coin_10` high for that cycle; the outputs are combinational from state and the FIFO head.
  - Credit adds 1 (₹5) or 2 (₹10) at the edge.
  - New credit ≥3 (₹15 or more): go to HOLD.
  - Owner FIFO empty: stay in SESSION and issue nothing. Other slots keep buffering; no preemption and no timeout.
- **FSM HOLD** (exactly 1 cycle, matching the core's S3/S4 cycle)
  - `coin_5`=`coin_10`=0.
  - `vend_done[owner]`=1.
  - `change_done[owner]` = (credit==4).
  - Set `err` if `dispense`≠1, or if `change_5`≠(credit==4).
  - Next: IDLE, credit←0, `rr_ptr`←(owner+1) mod `N_SLOTS`.
- **Monitoring**: `err` is also set if `dispense`=1 in IDLE or SESSION. `err` is cleared only by `rst`.
- **Reset values**: all outputs 0; `owner`=0; state IDLE; credit 0; all FIFOs empty; `rr_ptr`=0.
- **Reset mid-operation**: all buffered coins are dropped with no `reject` pulses. The core is reset by the same `rst`, so both sides restart at ₹0.

## Timing
- Slot pulse at edge t is in the FIFO from cycle t+1.
- From an empty IDLE, a coin arriving at cycle c gives:
  - grant decision at c+1;
  - SESSION and first issue at c+2.
- Issue rate: at most one coin per cycle to the core, on consecutive cycles allowed.
- The coin taking credit to ≥₹15 is issued in cycle s. Then:
  - HOLD is cycle s+1, the same cycle the core asserts `dispense`.
  - IDLE is cycle s+2.
  - The next grant takes effect at s+3.
- `reject` is a registered pulse, 1 cycle after the offending input.
- `owner_valid`=1 exactly in SESSION and HOLD.

## Test plan
- **Single ₹15 session**: slot 0 gets ₹5 then ₹10 (cycles 1, 2).
  - Required: `owner`=0 in SESSION; `coin_5` then `coin_10` to the core on consecutive cycles.
  - Required: `vend_done[0]` in HOLD with `change_done[0]`=0; `err`=0.
- **Change case**: slot 1 inserts ₹10, ₹10.
  - Required: core sees two `coin_10`; HOLD gives `vend_done[1]`=1, `change_done[1]`=1, `change_5`=1; `err`=0.
- **Round-robin and no preemption**: slots 0 and 1 each insert ₹10, ₹5 in the same cycles.
  - Required: slot 0 served first; slot 1's coins stay buffered until slot 0 vends.
  - Required: slot 1 is granted next; after that `rr_ptr`=0.
- **Overflow and illegal input**:
  - Slot 0 receives 5 coins while slot 1 owns the core and is idle: exactly 1 `reject[0]` pulse; the first 4 coins are later issued in order.
  - Simultaneous `slot_coin_5[1]`&`slot_coin_10[1]`: `reject[1]` pulse and no push.
- **Core mismatch**: force `dispense`=0 during HOLD.
  - Required: `err`=1 and it stays 1 until `rst`.
- **Reset mid-session**: assert `rst` after slot 0 has issued ₹10 with 2 coins buffered.
  - Required: next cycle all outputs 0, state IDLE, FIFOs empty.
  - Required: no `reject` pulse and no further coins issued.
